// File: rtl/countdown_sequencer.sv
// countdown_sequencer: loadable N-bit down-counter with start/stop/pause
// control, optional auto-reload on terminal count, a one-cycle done pulse
// and a saturating count of auto-reloads since the last start.
module countdown_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         auto_reload,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] count,
  output logic [1:0]   state,
  output logic         busy,
  output logic         done,
  output logic [7:0]   reload_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic [7:0]   rc_q, rc_d;

  // Decrement that stops at zero instead of wrapping to all-ones.
  function automatic logic [N-1:0] dec_floor(input logic [N-1:0] v);
    return (v == ZERO) ? ZERO : v - ONE;
  endfunction

  // Increment that holds at 255 once reached.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state and next-output decode; stop beats start beats pause.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    rc_d    = rc_q;
    if (stop) begin
      state_d = IDLE;
      count_d = ZERO;
      rc_d    = 8'd0;
    end else if (start) begin
      count_d = load_value;
      rc_d    = 8'd0;
      if (load_value != ZERO) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          count_d = ZERO;
        end
        RUN: begin
          if (pause) begin
            // Freeze on the pausing edge; the count is held as-is.
            state_d = PAUSED;
          end else if (count_q != ZERO) begin
            count_d = dec_floor(count_q);
          end else if (!auto_reload) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // Terminal count with reload: load_value is sampled on this edge.
            count_d = load_value;
            done_d  = 1'b1;
            rc_d    = sat_inc8(rc_q);
            if (load_value == ZERO) begin
              state_d = DONE;
            end
          end
        end
        PAUSED: begin
          // Resume without decrementing on the release edge.
          if (!pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          count_d = ZERO;
        end
        default: begin
          state_d = IDLE;
          count_d = ZERO;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= ZERO;
      done_q  <= 1'b0;
      rc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      rc_q    <= rc_d;
    end
  end

  assign state      = state_q;
  assign count      = count_q;
  assign done       = done_q;
  assign reload_cnt = rc_q;
  assign busy       = (state_q == RUN) || (state_q == PAUSED);

endmodule
